lfsr_param_gen: RTL and testbench
=================================

# lfsr_param_gen

Parametrised LFSR pseudo-random generator: configurable width, tap set and feedback structure (Fibonacci or Galois), with seed load, all-zero lock-up protection, a period-complete marker and a framed serial read-out port. Successor to the fixed 8-bit LFSR. Used as a PRBS/scrambler source feeding serial test links and BIST pattern paths.

## Interface
- WIDTH, 8: register width, legal range 3..32.
- TAPS, 8'hB8: feedback mask, WIDTH bits.
  - MODE=0 (Fibonacci): bit i set means lfsr[i] is XORed into the feedback.
  - MODE=1 (Galois): the mask is XORed into the shifted value when the MSB shifted out is 1 (8-bit maximal: 8'h71).
- MODE, 0: 0 = Fibonacci, 1 = Galois.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- seed  in  WIDTH  value written by load.
- load  in  1  load seed into lfsr this edge.
- enable  in  1  advance lfsr one step per cycle.
- out_enable  in  1  request a serial frame of the current lfsr.
- lfsr  out  WIDTH  current register state.
- serial_out  out  1  serial frame data, LSB first.
- valid  out  1  serial_out carries frame data.
- period_done  out  1  one-cycle pulse when a step returns lfsr to the last loaded seed.

## Operation
- Reset: lfsr = 1 (WIDTH-bit value 1), shift register = 0, serial_out = 0, valid = 0, period_done = 0, bit counter = 0, FSM = IDLE, seed latch = 1.
- Priority per edge: reset > load > out_enable start > enable step.
- Load:
  - lfsr <= seed. If seed == 0, load 1 instead (lock-up protection); the seed latch holds the same corrected value.
  - Any frame in progress aborts: FSM to IDLE, valid 0.
- Fibonacci step: fb = ^(lfsr & TAPS); lfsr <= {lfsr[WIDTH-2:0], fb}.
- Galois step: lfsr <= {lfsr[WIDTH-2:0], 1'b0} ^ (lfsr[WIDTH-1] ? TAPS : 0).
- Enable is honoured in IDLE only. During SHIFT, lfsr is frozen and enable is ignored.
- period_done pulses on the edge after a step whose result equals the seed latch.
- FSM:
  - IDLE: out_enable=1 -> capture lfsr into shift register, counter = 0, go to SHIFT.
  - SHIFT: serial_out = shreg[0], valid = 1. Each edge shifts right and increments the counter.
    - At counter == WIDTH-1 with out_enable=1: recapture lfsr and stay in SHIFT (gap-free back-to-back frames).
    - At counter == WIDTH-1 with out_enable=0: return to IDLE.
    - Dropping out_enable mid-frame does not truncate the frame.
- Reset mid-frame: valid and serial_out are 0 on the next cycle.

## Timing
- Load/step latency: 1 cycle; lfsr reflects the operation after the sampling edge.
- Frame: out_enable sampled high at edge N. valid=1 and serial_out=bit0 from edge N through edge N+WIDTH-1 (WIDTH cycles). valid=0 after edge N+WIDTH unless re-triggered.
- A frame captures lfsr as it was before edge N. A step requested in the same cycle as a frame start is dropped, because start has priority.
- period_done: registered; high for exactly one cycle.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Reset, then load=1 with seed=8'h92, then enable for 3 cycles (Fibonacci, TAPS=8'hB8) -> lfsr 8'h92, 8'h24, 8'h49, 8'h93.
- Seed=8'h93, then out_enable pulse for 1 cycle -> valid high for exactly 8 cycles; serial_out 1,1,0,0,1,0,0,1; lfsr stays 8'h93 throughout even with enable held high.
- Load seed=8'h00 -> lfsr=8'h01. Then enable for 255 cycles -> period_done pulses exactly once, on the 255th step; every lfsr value in between is nonzero and distinct.
- out_enable held high for 16 cycles with seed 8'h92 -> two contiguous 8-bit frames, valid never drops between them, both frames serialize 8'h92.
- Frame in progress, load=1 seed=8'h55 at bit 3 -> valid 0 next cycle and lfsr=8'h55. Separately: reset asserted mid-frame -> all outputs return to reset values next cycle.
- MODE=1, TAPS=8'h71, seed 8'h80, 2 enable steps -> lfsr 8'h71, then 8'hE2.

Source files
------------

// File: rtl/lfsr_param_gen_if.sv
// rtl/lfsr_param_gen_if.sv - control and observation bundle for the parametrised LFSR generator
interface lfsr_param_gen_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] seed;
  logic             load;
  logic             enable;
  logic             out_enable;
  logic [WIDTH-1:0] lfsr;
  logic             serial_out;
  logic             valid;
  logic             period_done;

  modport master (
    output seed, load, enable, out_enable,
    input  lfsr, serial_out, valid, period_done
  );

  modport slave (
    input  seed, load, enable, out_enable,
    output lfsr, serial_out, valid, period_done
  );
endinterface

// File: rtl/lfsr_param_gen.sv
// rtl/lfsr_param_gen.sv - parametrised Fibonacci/Galois LFSR with seed load, period marker and framed serial read-out
module lfsr_param_gen #(
  parameter int             WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter bit             MODE  = 1'b0
) (
  input logic             clk,
  input logic             reset,
  lfsr_param_gen_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             serial_q;
  logic             valid_q;
  logic             done_q;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] seed_fix;

  always_comb begin
    step_val = '0;
    if (MODE == 1'b0) begin
      step_val = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end else begin
      step_val = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? TAPS : '0);
    end
  end

  // An all-zero seed would lock the register up, so it is replaced by 1.
  assign seed_fix = (bus.seed == '0) ? WIDTH'(1) : bus.seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lfsr_q   <= WIDTH'(1);
      seed_q   <= WIDTH'(1);
      shreg    <= '0;
      cnt      <= '0;
      serial_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        lfsr_q   <= seed_fix;
        seed_q   <= seed_fix;
        state    <= IDLE;
        cnt      <= '0;
        serial_q <= 1'b0;
        valid_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.out_enable) begin
              shreg    <= lfsr_q;
              serial_q <= lfsr_q[0];
              valid_q  <= 1'b1;
              cnt      <= '0;
              state    <= SHIFT;
            end else if (bus.enable) begin
              lfsr_q <= step_val;
              done_q <= (step_val == seed_q);
            end
          end
          SHIFT: begin
            if (cnt == LAST) begin
              // Recapturing on the last bit keeps back-to-back frames gap-free.
              if (bus.out_enable) begin
                shreg    <= lfsr_q;
                serial_q <= lfsr_q[0];
                valid_q  <= 1'b1;
                cnt      <= '0;
              end else begin
                serial_q <= 1'b0;
                valid_q  <= 1'b0;
                cnt      <= '0;
                state    <= IDLE;
              end
            end else begin
              shreg    <= shreg >> 1;
              serial_q <= shreg[1];
              cnt      <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.lfsr        = lfsr_q;
  assign bus.serial_out  = serial_q;
  assign bus.valid       = valid_q;
  assign bus.period_done = done_q;

endmodule

// File: tb/tb_lfsr_param_gen.sv
// tb/tb_lfsr_param_gen.sv - scoreboard bench for lfsr_param_gen (Fibonacci and Galois instances)
module tb_lfsr_param_gen;

  logic clk;
  logic reset;

  lfsr_param_gen_if #(.WIDTH(8)) fif ();
  lfsr_param_gen_if #(.WIDTH(8)) gif ();

  lfsr_param_gen #(.WIDTH(8), .TAPS(8'hB8), .MODE(1'b0)) dut_fib (
    .clk   (clk),
    .reset (reset),
    .bus   (fif.slave)
  );

  lfsr_param_gen #(.WIDTH(8), .TAPS(8'h71), .MODE(1'b1)) dut_gal (
    .clk   (clk),
    .reset (reset),
    .bus   (gif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   ncmp  = 0;
  int   nfail = 0;
  bit   exp_bits[$];
  logic [7:0] m_lfsr;
  logic [7:0] m_seed;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference step from the polynomial rules using plain arithmetic.
  function automatic logic [7:0] ref_step(input logic [7:0] v, input bit galois, input logic [7:0] taps);
    int vi;
    int ones;
    int nxt;
    vi = int'(v);
    if (!galois) begin
      ones = 0;
      for (int i = 0; i < 8; i++)
        if (v[i] && taps[i]) ones++;
      nxt = (vi * 2 + ones % 2) % 256;
    end else begin
      nxt = (vi * 2) % 256;
      if (vi >= 128) nxt = nxt ^ int'(taps);
    end
    return nxt[7:0];
  endfunction

  always @(negedge clk) begin
    if (fif.valid === 1'b1) begin
      if (exp_bits.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL serial_unexpected valid got=1 want=0");
      end else begin
        bit b;
        b = exp_bits.pop_front();
        chk("serial_bit", fif.serial_out, b);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] s);
    fif.seed = s;
    fif.load = 1'b1;
    cyc();
    fif.load = 1'b0;
    m_lfsr = (s == 8'h00) ? 8'h01 : s;
    m_seed = m_lfsr;
    chk("load_lfsr", fif.lfsr, m_lfsr);
    chk("load_done", fif.period_done, 0);
  endtask

  task automatic steps(input int n);
    fif.enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc();
      m_lfsr = ref_step(m_lfsr, 1'b0, 8'hB8);
      chk("step_lfsr", fif.lfsr, m_lfsr);
      chk("step_done", fif.period_done, (m_lfsr == m_seed));
    end
    fif.enable = 1'b0;
  endtask

  task automatic frames(input int k, input bit en);
    fif.enable     = en;
    fif.out_enable = 1'b1;
    for (int f = 0; f < k; f++)
      for (int i = 0; i < 8; i++) exp_bits.push_back(m_lfsr[i]);
    for (int i = 0; i < 8 * k; i++) begin
      cyc();
      chk("frame_valid", fif.valid, 1);
      chk("frame_hold", fif.lfsr, m_lfsr);
    end
    fif.out_enable = 1'b0;
    fif.enable     = 1'b0;
    cyc();
    chk("frame_end_valid", fif.valid, 0);
    chk("frame_drain", exp_bits.size(), 0);
    chk("frame_end_lfsr", fif.lfsr, m_lfsr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int bad;
    int pulse_at;
    bit seen[256];

    reset = 1'b1;
    fif.seed = '0; fif.load = 0; fif.enable = 0; fif.out_enable = 0;
    gif.seed = '0; gif.load = 0; gif.enable = 0; gif.out_enable = 0;
    cyc();
    cyc();
    chk("rst_lfsr", fif.lfsr, 8'h01);
    chk("rst_valid", fif.valid, 0);
    chk("rst_serial", fif.serial_out, 0);
    chk("rst_done", fif.period_done, 0);
    chk("rst_gal_lfsr", gif.lfsr, 8'h01);
    reset = 1'b0;
    m_lfsr = 8'h01;
    m_seed = 8'h01;

    // Directed sequence from known Fibonacci values.
    do_load(8'h92);
    chk("dir_92", fif.lfsr, 8'h92);
    steps(3);
    chk("dir_93", fif.lfsr, 8'h93);

    do_load(8'h93);
    frames(1, 1'b1);
    chk("dir_frame_lfsr", fif.lfsr, 8'h93);

    do_load(8'h92);
    frames(2, 1'b0);

    // Full period from a zero seed.
    do_load(8'h00);
    chk("zero_seed", fif.lfsr, 8'h01);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    pulses = 0; bad = 0; pulse_at = -1;
    fif.enable = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      cyc();
      m_lfsr = ref_step(m_lfsr, 1'b0, 8'hB8);
      if (fif.lfsr !== m_lfsr) bad++;
      if (fif.period_done === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
      if (i < 255) begin
        if (fif.lfsr == 8'h00 || seen[fif.lfsr]) bad++;
        seen[fif.lfsr] = 1'b1;
      end
    end
    fif.enable = 1'b0;
    chk("period_bad_values", bad, 0);
    chk("period_pulses", pulses, 1);
    chk("period_pulse_step", pulse_at, 255);
    chk("period_back_to_seed", fif.lfsr, 8'h01);
    cyc();
    chk("period_done_clear", fif.period_done, 0);

    // Load aborts a frame at bit 3.
    do_load(8'h3C);
    for (int i = 0; i < 8; i++) exp_bits.push_back(m_lfsr[i]);
    fif.out_enable = 1'b1;
    cyc();
    fif.out_enable = 1'b0;
    cyc(); cyc(); cyc();
    fif.seed = 8'h55;
    fif.load = 1'b1;
    cyc();
    fif.load = 1'b0;
    exp_bits.delete();
    m_lfsr = 8'h55; m_seed = 8'h55;
    chk("abort_valid", fif.valid, 0);
    chk("abort_serial", fif.serial_out, 0);
    chk("abort_lfsr", fif.lfsr, 8'h55);

    // Reset aborts a frame.
    for (int i = 0; i < 8; i++) exp_bits.push_back(m_lfsr[i]);
    fif.out_enable = 1'b1;
    cyc();
    fif.out_enable = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    exp_bits.delete();
    chk("rstmid_valid", fif.valid, 0);
    chk("rstmid_serial", fif.serial_out, 0);
    chk("rstmid_lfsr", fif.lfsr, 8'h01);
    chk("rstmid_done", fif.period_done, 0);
    reset = 1'b0;
    m_lfsr = 8'h01; m_seed = 8'h01;

    // Galois instance.
    gif.seed = 8'h80;
    gif.load = 1'b1;
    cyc();
    gif.load = 1'b0;
    chk("gal_load", gif.lfsr, 8'h80);
    gif.enable = 1'b1;
    cyc();
    chk("gal_step1", gif.lfsr, 8'h71);
    chk("gal_step1_model", gif.lfsr, ref_step(8'h80, 1'b1, 8'h71));
    cyc();
    chk("gal_step2", gif.lfsr, 8'hE2);
    gif.enable = 1'b0;
    cyc();
    chk("gal_hold", gif.lfsr, 8'hE2);

    // Randomised mix of loads, step runs, idle cycles and frames.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: do_load(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        1: steps($urandom_range(1, 6));
        2: frames($urandom_range(1, 2), 1'($urandom_range(0, 1)));
        default: begin
          cyc();
          chk("idle_hold", fif.lfsr, m_lfsr);
          chk("idle_done", fif.period_done, 0);
        end
      endcase
    end

    cyc();
    chk("final_drain", exp_bits.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
